// File: rtl/sipo_deser.sv
// Serial-to-parallel deserialiser: collects WIDTH qualified bits into a word held on a valid/ready output.
// Optional even-parity frame bit enabled by defining SIPO_DESER_PARITY_EN.
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             s_in,
    input  logic             s_valid,
    output logic [WIDTH-1:0] p_out,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             overrun,
    output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    // The whole word must survive one extra bit time until the parity edge.
    localparam int SW    = WIDTH;
`else
    localparam int FRAME = WIDTH;
    // The bit that would be shifted out is never read again, so it is not stored.
    localparam int SW    = WIDTH - 1;
`endif
    localparam int             CW        = $clog2(FRAME);
    localparam logic [CW-1:0]  LAST_DATA = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  LAST_BIT  = CW'(FRAME - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("sipo_deser: WIDTH must be in 2..32");
        end
    endgenerate

    logic [SW-1:0]    shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] p_out_q, p_out_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;

    logic [WIDTH-2:0] hist;
    logic [WIDTH-1:0] word;
    logic [SW-1:0]    shift_next;
    logic [WIDTH-1:0] commit_word;
    logic             commit;
    logic             slot_free;

    generate
        if (LSB_FIRST) begin : g_lsb
            assign hist       = shift_q[SW-1 -: WIDTH-1];
            assign word       = {s_in, hist};
            assign shift_next = word[WIDTH-1 -: SW];
        end else begin : g_msb
            assign hist       = shift_q[WIDTH-2:0];
            assign word       = {hist, s_in};
            assign shift_next = word[SW-1:0];
        end
    endgenerate

    assign slot_free = ~p_valid_q | p_ready;

`ifdef SIPO_DESER_PARITY_EN
    logic parity_err_q, parity_err_d;
    logic parity_bad;

    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_word = shift_q;
        parity_bad  = 1'b0;
        if (s_valid) begin
            cnt_d = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
            if (cnt_q <= LAST_DATA) begin
                shift_d = shift_next;
            end
            if (cnt_q == LAST_BIT) begin
                commit     = 1'b1;
                parity_bad = (^shift_q) ^ s_in;
            end
        end
    end

    always_comb begin
        parity_err_d = parity_err_q;
        if (commit && parity_bad) begin
            parity_err_d = 1'b1;
        end
        if (clear) begin
            parity_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        commit      = 1'b0;
        commit_word = word;
        if (s_valid) begin
            cnt_d   = (cnt_q == LAST_BIT) ? '0 : cnt_q + 1'b1;
            shift_d = shift_next;
            commit  = (cnt_q == LAST_DATA);
        end
    end

    assign parity_err = 1'b0;
`endif

    // Output slot: a completed word either replaces a free/consumed slot or is dropped as an overrun.
    always_comb begin
        p_out_d   = p_out_q;
        p_valid_d = p_valid_q;
        overrun_d = overrun_q;
        if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
        if (commit) begin
            if (slot_free) begin
                p_out_d   = commit_word;
                p_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clear) begin
            p_out_d   = '0;
            p_valid_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q   <= '0;
            cnt_q     <= '0;
            p_out_q   <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            shift_q   <= clear ? '0 : shift_d;
            cnt_q     <= clear ? '0 : cnt_d;
            p_out_q   <= p_out_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_out   = p_out_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: an MSB-first and an LSB-first instance share one serial stream.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       s_in;
    logic       s_valid;
    logic       p_ready;
    logic [7:0] m_p_out, l_p_out;
    logic       m_p_valid, l_p_valid;
    logic       m_overrun, l_overrun;
    logic       m_parity_err, l_parity_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_in(s_in), .s_valid(s_valid),
        .p_out(m_p_out), .p_valid(m_p_valid), .p_ready(p_ready),
        .overrun(m_overrun), .parity_err(m_parity_err)
    );

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .reset_n(reset_n), .clear(clear), .s_in(s_in), .s_valid(s_valid),
        .p_out(l_p_out), .p_valid(l_p_valid), .p_ready(p_ready),
        .overrun(l_overrun), .parity_err(l_parity_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        s_in    = b;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sends w MSB-first on the wire; pbit is sent only when the parity frame bit exists.
    task automatic send_word(input logic [7:0] w, input logic pbit);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
`ifdef SIPO_DESER_PARITY_EN
        send_bit(pbit);
`else
        if (pbit) s_in = 1'b0;
`endif
    endtask

    // Idle cycles between bits carry the inverted bit on s_in so any sampling would corrupt the word.
    task automatic send_word_gap(input logic [7:0] w, input logic pbit, input int gap);
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            s_in = ~w[i];
            if (i != 0) idle(gap);
        end
`ifdef SIPO_DESER_PARITY_EN
        idle(gap);
        chk("gap_no_early_valid", 32'(m_p_valid), 32'd0);
        send_bit(pbit);
`else
        if (pbit) s_in = 1'b0;
`endif
    endtask

    initial begin
        reset_n = 1'b0;
        clear   = 1'b0;
        s_in    = 1'b0;
        s_valid = 1'b0;
        p_ready = 1'b1;
        #2;
        chk("reset_p_out",      32'(m_p_out), 32'h00);
        chk("reset_p_valid",    32'(m_p_valid), 32'd0);
        chk("reset_overrun",    32'(m_overrun), 32'd0);
        chk("reset_parity_err", 32'(m_parity_err), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic word, both bit orders
        send_word(8'hB2, ^8'hB2);
        chk("msb_word",       32'(m_p_out), 32'hB2);
        chk("lsb_word",       32'(l_p_out), 32'h4D);
        chk("basic_valid",    32'(m_p_valid), 32'd1);
        chk("basic_overrun",  32'(m_overrun), 32'd0);
        idle(1);
        chk("basic_valid_one_cycle", 32'(m_p_valid), 32'd0);
        chk("basic_p_out_held",      32'(m_p_out), 32'hB2);

        // Qualified input with idle gaps
        send_word_gap(8'hA1, ^8'hA1, 2);
        chk("gap_msb_word", 32'(m_p_out), 32'hA1);
        chk("gap_lsb_word", 32'(l_p_out), 32'h85);
        chk("gap_valid",    32'(m_p_valid), 32'd1);
        idle(1);

        // Backpressure and overrun
        p_ready = 1'b0;
        send_word(8'hA5, ^8'hA5);
        chk("bp_first_word",    32'(m_p_out), 32'hA5);
        chk("bp_first_overrun", 32'(m_overrun), 32'd0);
        send_word(8'h3C, ^8'h3C);
        chk("bp_word_stable",   32'(m_p_out), 32'hA5);
        chk("bp_valid_held",    32'(m_p_valid), 32'd1);
        chk("bp_overrun_set",   32'(m_overrun), 32'd1);
        chk("bp_lsb_overrun",   32'(l_overrun), 32'd1);
        p_ready = 1'b1;
        idle(1);
        chk("bp_drain_valid",   32'(m_p_valid), 32'd0);
        chk("bp_overrun_stick", 32'(m_overrun), 32'd1);
        chk("bp_drain_p_out",   32'(m_p_out), 32'hA5);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("clear_overrun", 32'(m_overrun), 32'd0);
        chk("clear_p_out",   32'(m_p_out), 32'h00);
        chk("clear_valid",   32'(m_p_valid), 32'd0);

        // Asynchronous reset mid-frame discards the partial word
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        reset_n = 1'b0;
        #2;
        chk("async_reset_valid", 32'(m_p_valid), 32'd0);
        #1;
        reset_n = 1'b1;
        send_word(8'hFF, ^8'hFF);
        chk("post_reset_word",  32'(m_p_out), 32'hFF);
        chk("post_reset_lsb",   32'(l_p_out), 32'hFF);
        chk("post_reset_valid", 32'(m_p_valid), 32'd1);

        // Back-to-back frames without gap cycles
        send_word(8'h81, ^8'h81);
        chk("b2b_first",  32'(m_p_out), 32'h81);
        chk("b2b_valid1", 32'(m_p_valid), 32'd1);
        send_word(8'h7E, ^8'h7E);
        chk("b2b_second",  32'(m_p_out), 32'h7E);
        chk("b2b_valid2",  32'(m_p_valid), 32'd1);
        chk("b2b_overrun", 32'(m_overrun), 32'd0);
        idle(1);
        chk("b2b_drained", 32'(m_p_valid), 32'd0);

`ifdef SIPO_DESER_PARITY_EN
        send_word(8'h07, 1'b1);
        chk("par_good_word", 32'(m_p_out), 32'h07);
        chk("par_good_lsb",  32'(l_p_out), 32'hE0);
        chk("par_good_flag", 32'(m_parity_err), 32'd0);
        send_word(8'h07, 1'b0);
        chk("par_bad_word",  32'(m_p_out), 32'h07);
        chk("par_bad_valid", 32'(m_p_valid), 32'd1);
        chk("par_bad_flag",  32'(m_parity_err), 32'd1);
        idle(1);
        chk("par_flag_stick", 32'(m_parity_err), 32'd1);
`else
        chk("parity_tied_msb", 32'(m_parity_err), 32'd0);
        chk("parity_tied_lsb", 32'(l_parity_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sipo_deser.md
Name: sipo_deser

Overview:
- Parametrised serial-to-parallel deserialiser. It accumulates WIDTH qualified serial bits into a word and presents the word on a valid/ready output interface.
- Successor to the fixed 4-bit shift register. Adds configurable width, bit order, input qualification, output holding with backpressure, and overrun detection.
- Sits between a serial link front-end and word-oriented downstream logic.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- LSB_FIRST, 0: 0 = first received bit lands in p_out[WIDTH-1] (MSB-first); 1 = first received bit lands in p_out[0].

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous clear; same effect as reset, one cycle.
- s_in  input  1  serial data bit.
- s_valid  input  1  s_in is sampled only when s_valid=1.
- p_out  output  WIDTH  parallel word; registered.
- p_valid  output  1  p_out holds an unconsumed word.
- p_ready  input  1  downstream accepts the word when p_valid & p_ready.
- overrun  output  1  sticky; a completed word was dropped.
- parity_err  output  1  sticky parity error (see Optional Feature).

Behaviour:
- Reset (reset_n=0, asynchronous) and clear=1 (synchronous) zero the following: shift register, bit counter, p_out, p_valid, overrun, parity_err. clear has priority over all other inputs in its cycle.
- Clock and reset: clock is clk; reset is reset_n, asynchronous, active-low.
- Bit counter: 0..FRAME-1, where FRAME=WIDTH (or WIDTH+1 when PARITY_EN is defined). It increments only on edges with s_valid=1 and wraps to 0 after the last bit of the frame. When s_valid=0, the shift register and counter hold.
- Shift rule, MSB-first: shift <= {shift[WIDTH-2:0], s_in}.
- Shift rule, LSB-first: shift <= {s_in, shift[WIDTH-1:1]}.
- Word completion: on the edge that samples the last data bit (counter = WIDTH-1, s_valid=1), the completed word is formed. This is the shift register combined with the current s_in, with zero extra latency. If the output slot is free, p_out loads the word and p_valid=1 is visible in the following cycle.
- Output slot free: p_valid=0, or p_valid=1 & p_ready=1 in the same cycle.
- Completion with slot free and a handshake in the same cycle: p_out is replaced, p_valid stays 1, overrun is not set.
- Completion with slot occupied (p_valid=1 & p_ready=0): the new word is discarded, p_out and p_valid are unchanged, and overrun is set to 1. Overrun stays 1 until reset or clear.
- Handshake with no completion: p_valid goes to 0 on the next edge. p_out retains its last value.
- p_out is stable while p_valid=1 & p_ready=0.
- Throughput: one word per FRAME valid bits. Back-to-back frames need no gap cycles.
- Reset asserted mid-frame: the partial word is lost. After release, the next valid bit is bit 0 of a new frame.

Optional Feature:
- Macro: SIPO_DESER_PARITY_EN.
- When defined: FRAME=WIDTH+1. After the WIDTH data bits, one even-parity bit is received; XOR of the data bits and the parity bit must be 0.
  - The word is committed to p_out on the parity-bit edge, not on the last data bit.
  - On mismatch, the word is still delivered normally and parity_err is set sticky until reset or clear.
  - Overrun rules apply at the parity-bit edge.
- When undefined: FRAME=WIDTH and parity_err is tied to 0.

Test Plan:
- Reset then WIDTH=8, LSB_FIRST=0, send bits 1,0,1,1,0,0,1,0 with s_valid=1 and p_ready=1 -> p_out=8'hB2, p_valid=1 for exactly one cycle, overrun=0.
- Same bits with LSB_FIRST=1 -> p_out=8'h4D.
- Send 3'b101 with s_valid held low for 2 cycles between each bit -> the held cycles do not shift; the word completes only after 8 valid bits.
- Hold p_ready=0, send word 8'hA5 then word 8'h3C -> p_out stays 8'hA5, p_valid stays 1, overrun=1 after the second word completes. Assert p_ready -> p_valid=0; overrun stays 1 until clear.
- Send 4 bits, pulse reset_n low asynchronously, then send 8'hFF -> output is 8'hFF with no residue from the partial frame.
- With SIPO_DESER_PARITY_EN defined, send 8'h07 + parity 1 -> p_out=8'h07, parity_err=0. Then send 8'h07 + parity 0 -> word delivered, parity_err=1.
